// File: rtl/fifo_pkg.sv
// Shared constants and types for the 8-bit, 16-deep synchronous FIFO and its
// read-side adapter.
package fifo_pkg;

  localparam int FIFO_DW           = 8;
  localparam int FIFO_DEPTH        = 16;
  localparam int ADAPTER_BUF_DEPTH = 2;

  typedef logic [FIFO_DW-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer for the FIFO read adapter: push/pop/flush with an
// occupancy count; the head entry is always presented on o_data.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW        = FIFO_DW,
  parameter int BUF_DEPTH = ADAPTER_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_push_data,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_data,
  output logic                         o_valid,
  output logic [$clog2(BUF_DEPTH):0]   o_occupancy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int OW = AW + 1;

  logic [DW-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_valid     = (r_occ != '0);
  assign o_occupancy = r_occ;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Read-side adapter for the team FIFO: issues reads around the one-cycle read
// latency, captures returned words and streams them out over valid/ready.
module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int DW        = FIFO_DW,
  parameter int BUF_DEPTH = ADAPTER_BUF_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         fifo_empty,
  input  logic [DW-1:0]                fifo_data_out,
  output logic                         fifo_rd_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DW-1:0]                m_data,
  output logic [$clog2(BUF_DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]             rd_count
);

  localparam int            OW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [OW:0]   W_LIMIT = (OW + 1)'(BUF_DEPTH);

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic             w_valid;
  logic [OW:0]      w_level;
  logic [OW-1:0]    w_occ;
  logic [DW-1:0]    w_data;
  logic             r_inflight;
  logic [CNT_W-1:0] r_rd_count;

  assign w_pop  = w_valid && m_ready;
  assign w_push = r_inflight && !flush;

  // Committed level counts the in-flight word and credits this cycle's pop,
  // so a full buffer being drained still accepts a new read every clock.
  always_comb begin
    w_level = {1'b0, w_occ} + {{OW{1'b0}}, r_inflight} - {{OW{1'b0}}, w_pop};
    w_issue = !rst && en && !flush && !fifo_empty && (w_level < W_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_rd_count <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_pop && !flush) begin
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
    end
  end

  fifo_rd_skid_buf #(
    .DW        (DW),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_push      (w_push),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_data      (w_data),
    .o_valid     (w_valid),
    .o_occupancy (w_occ)
  );

  assign fifo_rd_en = w_issue;
  assign m_valid    = w_valid;
  assign m_data     = w_data;
  assign occupancy  = w_occ;
  assign rd_count   = r_rd_count;

endmodule
